// File: rtl/rst_seq_pkg.sv
// Shared types and codes for the reset sequencer.
package rst_seq_pkg;

    typedef enum logic [1:0] {
        WAIT_LOCK  = 2'd0,
        REL_PERIPH = 2'd1,
        RUN        = 2'd2,
        SW_HOLD    = 2'd3
    } state_e;

    localparam int unsigned CAUSE_W = 2;

    localparam logic [CAUSE_W-1:0] CAUSE_EXT  = 2'b00;
    localparam logic [CAUSE_W-1:0] CAUSE_LOCK = 2'b01;
    localparam logic [CAUSE_W-1:0] CAUSE_SW   = 2'b10;

endpackage : rst_seq_pkg

// File: rtl/rst_sequencer_sync_2ff.sv
// 1-bit two-flop synchronizer with async active-low clear.
module sync_2ff (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    // Two back-to-back flops to resolve metastability on the async input.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule : sync_2ff

// File: rtl/rst_sequencer.sv
// Reset sequencer: waits for stable PLL lock, releases peripheral then core
// reset, handles software reset requests and records the last reset cause.
// Optional macro RST_SEQ_LOCK_LOSS_EN: lock loss while running re-enters the
// reset sequence with cause LOCK; when undefined lock is ignored in RUN.
module rst_sequencer
    import rst_seq_pkg::*;
#(
    parameter int unsigned LOCK_STABLE_CYCLES = 256,
    parameter int unsigned CORE_DLY           = 16,
    parameter int unsigned SW_RST_CYCLES      = 32,
    parameter int unsigned CNT_W              = 10
) (
    input  logic               clkin,
    input  logic               reset,
    input  logic               lock,
    input  logic               sw_rst_req,
    output logic               periph_rst_n,
    output logic               sys_rst_n,
    output logic               seq_done,
    output logic [CAUSE_W-1:0] rst_cause
);

    localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CORE_LAST = CNT_W'(CORE_DLY - 1);
    localparam logic [CNT_W-1:0] SW_LAST   = CNT_W'(SW_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    logic               lock_s;

    state_e             state_q,  state_d;
    logic [CNT_W-1:0]   cnt_q,    cnt_d;
    logic               periph_q, periph_d;
    logic               sys_q,    sys_d;
    logic               done_q,   done_d;
    logic [CAUSE_W-1:0] cause_q,  cause_d;

    sync_2ff u_lock_sync (
        .clk_i  (clkin),
        .rst_ni (reset),
        .d_i    (lock),
        .q_o    (lock_s)
    );

    // Next-state and next-output decode; every register holds by default.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        periph_d = periph_q;
        sys_d    = sys_q;
        done_d   = done_q;
        cause_d  = cause_q;

        case (state_q)
            WAIT_LOCK: begin
                periph_d = 1'b0;
                sys_d    = 1'b0;
                done_d   = 1'b0;
                if (!lock_s) begin
                    cnt_d = '0;
                end else if (cnt_q == LOCK_LAST) begin
                    state_d  = REL_PERIPH;
                    cnt_d    = '0;
                    periph_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            REL_PERIPH: begin
                if (!lock_s) begin
                    state_d  = WAIT_LOCK;
                    cnt_d    = '0;
                    periph_d = 1'b0;
                end else if (cnt_q == CORE_LAST) begin
                    state_d = RUN;
                    cnt_d   = '0;
                    sys_d   = 1'b1;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            RUN: begin
`ifdef RST_SEQ_LOCK_LOSS_EN
                if (!lock_s) begin
                    state_d  = WAIT_LOCK;
                    cnt_d    = '0;
                    periph_d = 1'b0;
                    sys_d    = 1'b0;
                    done_d   = 1'b0;
                    cause_d  = CAUSE_LOCK;
                end else if (sw_rst_req) begin
`else
                if (sw_rst_req) begin
`endif
                    state_d  = SW_HOLD;
                    cnt_d    = '0;
                    periph_d = 1'b0;
                    sys_d    = 1'b0;
                    done_d   = 1'b0;
                    cause_d  = CAUSE_SW;
                end
            end

            SW_HOLD: begin
                if (cnt_q == SW_LAST) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            default: begin
                state_d  = WAIT_LOCK;
                cnt_d    = '0;
                periph_d = 1'b0;
                sys_d    = 1'b0;
                done_d   = 1'b0;
            end
        endcase
    end

    // State, counter and output registers; async clear drops both resets at once.
    always_ff @(posedge clkin or negedge reset) begin
        if (!reset) begin
            state_q  <= WAIT_LOCK;
            cnt_q    <= '0;
            periph_q <= 1'b0;
            sys_q    <= 1'b0;
            done_q   <= 1'b0;
            cause_q  <= CAUSE_EXT;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            periph_q <= periph_d;
            sys_q    <= sys_d;
            done_q   <= done_d;
            cause_q  <= cause_d;
        end
    end

    assign periph_rst_n = periph_q;
    assign sys_rst_n    = sys_q;
    assign seq_done     = done_q;
    assign rst_cause    = cause_q;

endmodule : rst_sequencer

// File: tb/tb_rst_sequencer.sv
// Directed bench for rst_sequencer with LOCK_STABLE_CYCLES=8, CORE_DLY=4,
// SW_RST_CYCLES=3. Expectations follow RST_SEQ_LOCK_LOSS_EN when defined.
module tb_rst_sequencer;

    logic       clk;
    logic       reset;
    logic       lock;
    logic       sw_rst_req;
    logic       periph_rst_n;
    logic       sys_rst_n;
    logic       seq_done;
    logic [1:0] rst_cause;

    int vectors;
    int miscompares;

    rst_sequencer #(
        .LOCK_STABLE_CYCLES (8),
        .CORE_DLY           (4),
        .SW_RST_CYCLES      (3),
        .CNT_W              (10)
    ) dut (
        .clkin        (clk),
        .reset        (reset),
        .lock         (lock),
        .sw_rst_req   (sw_rst_req),
        .periph_rst_n (periph_rst_n),
        .sys_rst_n    (sys_rst_n),
        .seq_done     (seq_done),
        .rst_cause    (rst_cause)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance n rising edges, then settle 1 time unit before sampling.
    task automatic edges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic p, input logic s,
                           input logic d, input logic [1:0] c);
        chk({tag, ".periph"}, 2'(periph_rst_n), 2'(p));
        chk({tag, ".sys"},    2'(sys_rst_n),    2'(s));
        chk({tag, ".done"},   2'(seq_done),     2'(d));
        chk({tag, ".cause"},  rst_cause,        c);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b0;
        lock        = 1'b0;
        sw_rst_req  = 1'b0;

        // Reset state
        #3;
        chk_all("rst", 1'b0, 1'b0, 1'b0, 2'b00);
        edges(2);
        chk_all("rst_hold", 1'b0, 1'b0, 1'b0, 2'b00);

        // Power-up: lock raised before edge k
        @(negedge clk);
        reset = 1'b1;
        lock  = 1'b1;
        edges(9);
        chk("pwr.k8_periph", 2'(periph_rst_n), 2'b0);
        edges(1);
        chk("pwr.k9_periph", 2'(periph_rst_n), 2'b1);
        chk("pwr.k9_sys",    2'(sys_rst_n),    2'b0);
        edges(3);
        chk("pwr.k12_sys",   2'(sys_rst_n),    2'b0);
        chk("pwr.k12_done",  2'(seq_done),     2'b0);
        edges(1);
        chk_all("pwr.k13", 1'b1, 1'b1, 1'b1, 2'b00);

        // Lock loss in RUN
        lock = 1'b0;
        edges(2);
        chk_all("ll.j1", 1'b1, 1'b1, 1'b1, 2'b00);
        edges(1);
`ifdef RST_SEQ_LOCK_LOSS_EN
        chk_all("ll.j2", 1'b0, 1'b0, 1'b0, 2'b01);
        edges(4);
        chk_all("ll.hold", 1'b0, 1'b0, 1'b0, 2'b01);
`else
        chk_all("ll.j2", 1'b1, 1'b1, 1'b1, 2'b00);
        edges(4);
        chk_all("ll.hold", 1'b1, 1'b1, 1'b1, 2'b00);
`endif

        // Async reset clears everything immediately
        #2 reset = 1'b0;
        #1;
        chk_all("arst1", 1'b0, 1'b0, 1'b0, 2'b00);
        #2 reset = 1'b1;

        // Lock glitch, with sw_rst_req held high to show it is ignored outside RUN
        sw_rst_req = 1'b1;
        lock       = 1'b1;
        edges(5);
        lock = 1'b0;
        edges(1);
        lock = 1'b1;
        edges(4);
        chk("gl.g3_periph", 2'(periph_rst_n), 2'b0);
        sw_rst_req = 1'b0;
        edges(5);
        chk("gl.g8_periph", 2'(periph_rst_n), 2'b0);
        edges(1);
        chk_all("gl.g9", 1'b1, 1'b0, 1'b0, 2'b00);
        edges(4);
        chk_all("gl.g13", 1'b1, 1'b1, 1'b1, 2'b00);

        // Software reset from RUN
        sw_rst_req = 1'b1;
        edges(1);
        sw_rst_req = 1'b0;
        chk_all("sw.s0", 1'b0, 1'b0, 1'b0, 2'b10);
        edges(10);
        chk("sw.s10_periph", 2'(periph_rst_n), 2'b0);
        edges(1);
        chk("sw.s11_periph", 2'(periph_rst_n), 2'b1);
        chk("sw.s11_sys",    2'(sys_rst_n),    2'b0);
        edges(3);
        chk("sw.s14_sys",    2'(sys_rst_n),    2'b0);
        edges(1);
        chk_all("sw.s15", 1'b1, 1'b1, 1'b1, 2'b10);

`ifdef RST_SEQ_LOCK_LOSS_EN
        // Lock loss and sw request seen on the same edge: lock loss wins
        lock = 1'b0;
        edges(2);
        chk_all("sim.j1", 1'b1, 1'b1, 1'b1, 2'b10);
        sw_rst_req = 1'b1;
        edges(1);
        sw_rst_req = 1'b0;
        chk_all("sim.j2", 1'b0, 1'b0, 1'b0, 2'b01);
        edges(3);
        chk_all("sim.hold", 1'b0, 1'b0, 1'b0, 2'b01);
`endif

        // Async reset while in REL_PERIPH, then full restart
        lock = 1'b1;
        #2 reset = 1'b0;
        #2 reset = 1'b1;
        edges(10);
        chk_all("rp.k9", 1'b1, 1'b0, 1'b0, 2'b00);
        edges(1);
        #2 reset = 1'b0;
        #1;
        chk_all("rp.arst", 1'b0, 1'b0, 1'b0, 2'b00);
        #2 reset = 1'b1;
        edges(9);
        chk("rp.k8_periph", 2'(periph_rst_n), 2'b0);
        edges(1);
        chk("rp.k9_periph", 2'(periph_rst_n), 2'b1);
        edges(4);
        chk_all("rp.k13", 1'b1, 1'b1, 1'b1, 2'b00);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_rst_sequencer
